// File: rtl/scr1_btb_dp_ram.sv
// Simple dual-port BTB storage: one write port, one registered read port, valid bit per entry.
// A flush (or reset) sweeps every entry to {0, 0} before writes are accepted again.
module scr1_btb_dp_ram #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 32,
  parameter int BYPASS    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wena,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         renb,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  output logic [RAM_WIDTH-1:0]         doutb,
  output logic                         doutb_vld,
  output logic                         busy
);

  localparam int AW = $clog2(RAM_DEPTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_RAM  = 2'd1;
  localparam logic [1:0] SRC_BYP  = 2'd2;

  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(RAM_DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(RAM_DEPTH - 1);

  // {valid, payload}; deliberately unreset so it maps onto block RAM
  logic [RAM_WIDTH:0] mem [RAM_DEPTH];

  logic [0:0]          state_reg;
  logic [0:0]          state_next;
  logic [AW-1:0]       sweep_cnt_reg;
  logic [AW-1:0]       sweep_cnt_next;
  logic                busy_reg;

  logic                addra_ok;
  logic                addrb_ok;
  logic                wr_req;
  logic                ram_we;
  logic [AW-1:0]       ram_waddr;
  logic [RAM_WIDTH:0]  ram_wdata;
  logic                rd_hit;
  logic                byp_hit;

  logic [RAM_WIDTH:0]  ram_q_reg;
  logic [RAM_WIDTH-1:0] byp_data_reg;
  logic [1:0]          src_reg;

  assign addra_ok = ({1'b0, addra} < DEPTH_EXT);
  assign addrb_ok = ({1'b0, addrb} < DEPTH_EXT);

  // A flush in the same cycle takes priority over any write
  assign wr_req = (state_reg == IDLE) && wena && !flush && addra_ok;

  assign ram_we    = (state_reg == SWEEP) || wr_req;
  assign ram_waddr = (state_reg == SWEEP) ? sweep_cnt_reg : addra;
  assign ram_wdata = (state_reg == SWEEP) ? '0 : {1'b1, dina};

  assign rd_hit  = renb && (state_reg == IDLE) && addrb_ok;
  assign byp_hit = (BYPASS != 0) && wr_req && (addra == addrb);

  always_comb begin
    state_next     = state_reg;
    sweep_cnt_next = sweep_cnt_reg;
    if (flush) begin
      state_next     = SWEEP;
      sweep_cnt_next = '0;
    end else if (state_reg == SWEEP) begin
      if (sweep_cnt_reg == LAST_IDX) begin
        state_next     = IDLE;
        sweep_cnt_next = '0;
      end else begin
        sweep_cnt_next = sweep_cnt_reg + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= SWEEP;
      sweep_cnt_reg <= '0;
      busy_reg      <= 1'b1;
    end else begin
      state_reg     <= state_next;
      sweep_cnt_reg <= sweep_cnt_next;
      busy_reg      <= (state_next == SWEEP);
    end
  end

  assign busy = busy_reg;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  // Read-first port: a same-address write lands after this capture
  always_ff @(posedge clk) begin
    if (rd_hit) begin
      ram_q_reg <= mem[addrb];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_hit && byp_hit) begin
      byp_data_reg <= dina;
    end
  end

  // The source selector carries the reset, so the unreset data registers never leak out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_reg <= SRC_ZERO;
    end else if (renb) begin
      if (!rd_hit) begin
        src_reg <= SRC_ZERO;
      end else if (byp_hit) begin
        src_reg <= SRC_BYP;
      end else begin
        src_reg <= SRC_RAM;
      end
    end
  end

  always_comb begin
    doutb     = '0;
    doutb_vld = 1'b0;
    case (src_reg)
      SRC_RAM: begin
        doutb     = ram_q_reg[RAM_WIDTH-1:0];
        doutb_vld = ram_q_reg[RAM_WIDTH];
      end
      SRC_BYP: begin
        doutb     = byp_data_reg;
        doutb_vld = 1'b1;
      end
      default: begin
        doutb     = '0;
        doutb_vld = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_scr1_btb_dp_ram.sv
// Three instances share one stimulus stream: depth 32 with/without bypass, and depth 20.
// A behavioural model predicts reads into a scoreboard queue, popped one edge later.
module tb_scr1_btb_dp_ram;

  typedef struct packed {
    logic [2:0][31:0] d;
    logic [2:0]       v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush = 1'b0;
  logic        wena = 1'b0;
  logic [4:0]  addra = '0;
  logic [31:0] dina = '0;
  logic        renb = 1'b0;
  logic [4:0]  addrb = '0;
  logic [31:0] doutb [3];
  logic        doutb_vld [3];
  logic        busy [3];

  int          depth_c [3] = '{32, 32, 20};
  bit          byp_c [3]   = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m_data [3][32];
  bit          m_vld [3][32];
  int          rem [3];
  exp_t        sb [$];
  exp_t        held;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  scr1_btb_dp_ram #(.RAM_WIDTH(32), .RAM_DEPTH(32), .BYPASS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wena(wena), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(doutb[0]), .doutb_vld(doutb_vld[0]), .busy(busy[0]));

  scr1_btb_dp_ram #(.RAM_WIDTH(32), .RAM_DEPTH(32), .BYPASS(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wena(wena), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(doutb[1]), .doutb_vld(doutb_vld[1]), .busy(busy[1]));

  scr1_btb_dp_ram #(.RAM_WIDTH(32), .RAM_DEPTH(20), .BYPASS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wena(wena), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(doutb[2]), .doutb_vld(doutb_vld[2]), .busy(busy[2]));

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, d, obs, exp);
    end
  endtask

  task automatic invalidate(input int d);
    for (int i = 0; i < 32; i++) m_vld[d][i] = 1'b0;
  endtask

  // One clock edge: predict, advance the model, then compare every output
  task automatic tick();
    exp_t e;
    bit   rd;
    e  = '0;
    rd = renb;
    if (renb) begin
      for (int d = 0; d < 3; d++) begin
        if (rem[d] > 0 || int'(addrb) >= depth_c[d]) begin
          e.d[d] = '0;
          e.v[d] = 1'b0;
        end else if (byp_c[d] && wena && !flush && addra == addrb) begin
          e.d[d] = dina;
          e.v[d] = 1'b1;
        end else begin
          e.d[d] = m_vld[d][addrb] ? m_data[d][addrb] : 32'h0;
          e.v[d] = m_vld[d][addrb];
        end
      end
      sb.push_back(e);
    end
    for (int d = 0; d < 3; d++) begin
      if (rem[d] == 0 && wena && !flush && int'(addra) < depth_c[d]) begin
        m_data[d][addra] = dina;
        m_vld[d][addra]  = 1'b1;
      end
      if (flush) begin
        rem[d] = depth_c[d];
        invalidate(d);
      end else if (rem[d] > 0) begin
        rem[d]--;
      end
    end
    @(posedge clk);
    #1;
    if (rd) held = sb.pop_front();
    for (int d = 0; d < 3; d++) begin
      chk("doutb", d, doutb[d], held.d[d]);
      chk("doutb_vld", d, {31'b0, doutb_vld[d]}, {31'b0, held.v[d]});
      chk("busy", d, {31'b0, busy[d]}, (rem[d] > 0) ? 32'h1 : 32'h0);
    end
  endtask

  task automatic op(input bit w, input int wa, input logic [31:0] wd,
                    input bit r, input int ra, input bit f);
    wena  = w;
    addra = 5'(wa);
    dina  = wd;
    renb  = r;
    addrb = 5'(ra);
    flush = f;
    tick();
    wena  = 1'b0;
    renb  = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    flush = 1'b0;
    wena  = 1'b0;
    renb  = 1'b0;
    rst_n = 1'b0;
    #1;
    sb.delete();
    held = '0;
    for (int d = 0; d < 3; d++) begin
      rem[d] = depth_c[d];
      invalidate(d);
      chk("rst_busy", d, {31'b0, busy[d]}, 32'h1);
      chk("rst_doutb", d, doutb[d], 32'h0);
      chk("rst_vld", d, {31'b0, doutb_vld[d]}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    #2;
    do_reset();

    // Reset release: read during sweep, then sweep completion
    idle(3);
    op(1'b0, 0, 32'h0, 1'b1, 5, 1'b0);
    idle(29);
    op(1'b0, 0, 32'h0, 1'b1, 5, 1'b0);

    // Write then read
    op(1'b1, 7, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    op(1'b0, 0, 32'h0, 1'b1, 7, 1'b0);

    // Same-cycle write/read, bypass vs old data
    op(1'b1, 3, 32'h0000AAAA, 1'b0, 0, 1'b0);
    op(1'b1, 3, 32'h00001234, 1'b1, 3, 1'b0);
    op(1'b0, 0, 32'h0, 1'b1, 3, 1'b0);

    // Hold: renb low while addrb toggles
    op(1'b0, 0, 32'h0, 1'b1, 7, 1'b0);
    for (int i = 0; i < 5; i++) op(1'b0, 0, 32'h0, 1'b0, (i * 7 + 1) % 32, 1'b0);

    // Out-of-range for depth 20, last entry round trip
    op(1'b1, 25, 32'h00002525, 1'b0, 0, 1'b0);
    op(1'b0, 0, 32'h0, 1'b1, 25, 1'b0);
    op(1'b1, 19, 32'h00001919, 1'b0, 0, 1'b0);
    op(1'b0, 0, 32'h0, 1'b1, 19, 1'b0);

    // Flush with write and read in the same cycle, then a restart mid-sweep
    op(1'b1, 2, 32'h00000077, 1'b0, 0, 1'b0);
    op(1'b1, 2, 32'h00000055, 1'b1, 7, 1'b1);
    idle(5);
    op(1'b1, 9, 32'h00000099, 1'b1, 2, 1'b0);
    idle(3);
    op(1'b0, 0, 32'h0, 1'b0, 0, 1'b1);
    idle(31);
    op(1'b0, 0, 32'h0, 1'b1, 2, 1'b0);
    op(1'b0, 0, 32'h0, 1'b1, 9, 1'b0);

    // Reset asserted mid-sweep with a read pending
    op(1'b1, 4, 32'h00004444, 1'b0, 0, 1'b0);
    op(1'b0, 0, 32'h0, 1'b1, 4, 1'b0);
    op(1'b0, 0, 32'h0, 1'b0, 0, 1'b1);
    idle(3);
    renb  = 1'b1;
    addrb = 5'd4;
    do_reset();
    idle(32);
    op(1'b0, 0, 32'h0, 1'b1, 4, 1'b0);

    // Mixed random traffic
    for (int i = 0; i < 300; i++) begin
      op(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom(),
         1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
         ($urandom_range(0, 59) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
